// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_pkg : shared types and constants for the nibble-serial ALU sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   typedef logic [3:0] nibble_t;

   localparam nibble_t ALU_OP_ADD = 4'b1001;

endpackage
`default_nettype wire

// File: rtl/alu_nibble_sequencer_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ALU : purely combinational 4-bit ALU slice with carry in/out and overflow
// Rev 1.0
// ---------------------------------------------------------------------------
module ALU
   import alu_seq_pkg::*;
(
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [3:0] S,
   input  logic       Cin,
   output logic [3:0] result,
   output logic       Cout,
   output logic       overflow
);

   logic [4:0] sum_w;
   logic [3:0] b_eff_w;

   always_comb begin
      b_eff_w  = (S == 4'b0110) ? ~B : B;
      sum_w    = {1'b0, A} + {1'b0, b_eff_w} + {4'b0000, Cin};
      result   = A;
      Cout     = Cin;
      overflow = 1'b0;
      // Logic functions pass the carry straight through and never overflow.
      case (S)
         ALU_OP_ADD, 4'b0110: begin
            result   = sum_w[3:0];
            Cout     = sum_w[4];
            overflow = (A[3] == b_eff_w[3]) && (sum_w[3] != A[3]);
         end
         4'b1011: result = A & B;
         4'b1110: result = A | B;
         4'b0100: result = A ^ B;
         default: result = A;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_nibble_sequencer : runs WIDTH-bit ops on one 4-bit ALU, a nibble per
// clock, LSB first. Optional rsp_zero output with ALU_SEQ_ZERO_FLAG_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_nibble_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [3:0]       req_s,
   input  logic             req_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_cout,
   output logic             rsp_overflow,
   output logic             busy
`ifdef ALU_SEQ_ZERO_FLAG_EN
   ,
   output logic             rsp_zero
`endif
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
      $error("WIDTH must be a multiple of 4 and at least 4");
   end

   seq_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   nibble_t          s_q, s_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d, ovf_q, ovf_d;
   logic             req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;
   logic             zero_q, zero_d;

   nibble_t          alu_a_w, alu_b_w, alu_f_w;
   logic             alu_cout_w, alu_ovf_w;

   ALU u_alu (
      .A        (alu_a_w),
      .B        (alu_b_w),
      .S        (s_q),
      .Cin      (carry_q),
      .result   (alu_f_w),
      .Cout     (alu_cout_w),
      .overflow (alu_ovf_w)
   );

   always_comb begin
      alu_a_w = '0;
      alu_b_w = '0;
      for (int n = 0; n < NIB; n++) begin
         if (idx_q == IDXW'(n)) begin
            alu_a_w = a_q[4*n +: 4];
            alu_b_w = b_q[4*n +: 4];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      s_d         = s_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      result_d    = result_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      zero_d      = zero_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d         = req_a;
               b_d         = req_b;
               s_d         = req_s;
               carry_d     = req_cin;
               result_d    = '0;
               idx_d       = '0;
               zero_d      = 1'b1;
               state_d     = RUN;
               req_ready_d = 1'b0;
               busy_d      = 1'b1;
            end
         end
         RUN: begin
            for (int n = 0; n < NIB; n++) begin
               if (idx_q == IDXW'(n)) begin
                  result_d[4*n +: 4] = alu_f_w;
               end
            end
            carry_d = alu_cout_w;
            ovf_d   = alu_ovf_w;
            // Zero flag accumulates per nibble so no WIDTH-wide reduction is needed.
            zero_d  = zero_q & (alu_f_w == 4'h0);
            if (idx_q == IDXW'(NIB - 1)) begin
               state_d     = DONE;
               rsp_valid_d = 1'b1;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         result_q    <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         result_q    <= result_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         zero_q      <= zero_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign busy         = busy_q;
   assign rsp_result   = result_q;
   assign rsp_cout     = carry_q;
   assign rsp_overflow = ovf_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
   assign rsp_zero = zero_q;
`else
   logic unused_zero_w;
   assign unused_zero_w = zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_nibble_sequencer : directed bench with an arithmetic reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_nibble_sequencer;
   import alu_seq_pkg::*;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [WIDTH-1:0] req_a = '0;
   logic [WIDTH-1:0] req_b = '0;
   logic [3:0]       req_s = ALU_OP_ADD;
   logic             req_cin = 1'b0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_cout;
   logic             rsp_overflow;
   logic             busy;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic             rsp_zero;
`endif

   alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_s        (req_s),
      .req_cin      (req_cin),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_cout     (rsp_cout),
      .rsp_overflow (rsp_overflow),
      .busy         (busy)
`ifdef ALU_SEQ_ZERO_FLAG_EN
      ,
      .rsp_zero     (rsp_zero)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             co;
      logic             ov;
      int               acc;
   } op_t;

   op_t q[$];

   function automatic op_t model_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic cin, input int acc);
      op_t o;
      logic [WIDTH:0] sum;
      sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      o.res = sum[WIDTH-1:0];
      o.co  = sum[WIDTH];
      o.ov  = (a[WIDTH-1] == b[WIDTH-1]) && (o.res[WIDTH-1] != a[WIDTH-1]);
      o.acc = acc;
      return o;
   endfunction

   // Model: a response is valid from the NIB-th cycle after acceptance until handshake.
   logic             rst_edge = 1'b1;
   logic             hs_prev  = 1'b0;
   logic [WIDTH-1:0] last_res = '0;
   logic             last_co  = 1'b0;
   logic             last_ov  = 1'b0;

   always @(negedge clk) begin
      logic exp_valid;
      exp_valid = (q.size() > 0) && (cyc >= q[0].acc + NIB);
      if (rst_edge) begin
         chk("reset_result", rsp_result, 0);
         chk("reset_cout", rsp_cout, 0);
         chk("reset_ovf", rsp_overflow, 0);
      end else if (hs_prev) begin
         chk("hold_result", rsp_result, last_res);
         chk("hold_cout", rsp_cout, last_co);
         chk("hold_ovf", rsp_overflow, last_ov);
      end
      chk("rsp_valid", rsp_valid, exp_valid);
      chk("req_ready", req_ready, q.size() == 0);
      chk("busy", busy, q.size() != 0);
      if (exp_valid) begin
         chk("rsp_result", rsp_result, q[0].res);
         chk("rsp_cout", rsp_cout, q[0].co);
         chk("rsp_overflow", rsp_overflow, q[0].ov);
`ifdef ALU_SEQ_ZERO_FLAG_EN
         chk("rsp_zero", rsp_zero, q[0].res == 0);
`endif
      end
      hs_prev = 1'b0;
      if (rst) begin
         q.delete();
      end else begin
         if (exp_valid && rsp_ready) begin
            last_res = q[0].res;
            last_co  = q[0].co;
            last_ov  = q[0].ov;
            void'(q.pop_front());
            hs_prev = 1'b1;
         end
         if (req_valid && q.size() == 0 && !hs_prev)
            q.push_back(model_add(req_a, req_b, req_cin, cyc + 1));
      end
      rst_edge = rst;
   end

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                         output logic [WIDTH-1:0] r, output logic co, output logic ov,
                         output logic z, output int lat);
      int n;
      int acc;
      @(posedge clk); #1;
      req_valid = 1'b1; req_a = a; req_b = b; req_cin = cin; req_s = ALU_OP_ADD;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 40);
      chk("accept_timeout", req_ready, 1);
      acc = cyc + 1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!(rsp_valid && rsp_ready) && n < 40);
      chk("rsp_timeout", rsp_valid && rsp_ready, 1);
      r   = rsp_result;
      co  = rsp_cout;
      ov  = rsp_overflow;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      z   = rsp_zero;
`else
      z   = (rsp_result == 0);
`endif
      lat = cyc - acc + 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] r;
      logic co, ov, z;
      int lat;
      int n;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", req_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_busy", busy, 0);

      run_op(16'h1234, 16'h0FFF, 1'b0, r, co, ov, z, lat);
      chk("t1_result", r, 16'h2233);
      chk("t1_cout", co, 0);
      chk("t1_ovf", ov, 0);
      chk("t1_latency", lat, 5);

      run_op(16'hFFFF, 16'h0001, 1'b0, r, co, ov, z, lat);
      chk("t2_result", r, 16'h0000);
      chk("t2_cout", co, 1);
      chk("t2_ovf", ov, 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      chk("t2_zero", z, 1);
`endif

      run_op(16'h7FFF, 16'h0001, 1'b0, r, co, ov, z, lat);
      chk("t3_result", r, 16'h8000);
      chk("t3_cout", co, 0);
      chk("t3_ovf", ov, 1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      chk("t3_zero", z, 0);
`endif

      run_op(16'h0000, 16'h0000, 1'b1, r, co, ov, z, lat);
      chk("t3b_result", r, 16'h0001);
      chk("t3b_cout", co, 0);

      // Back-pressure: response held while a competing request is offered.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_a = 16'h1111; req_b = 16'h2222; req_cin = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 40);
      chk("t4_accept_timeout", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
      chk("t4_rsp_timeout", rsp_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_a = 16'hAAAA; req_b = 16'h5555; req_cin = 1'b1;
         @(negedge clk);
         chk("t4_hold_result", rsp_result, 16'h3333);
         chk("t4_hold_valid", rsp_valid, 1);
         chk("t4_ready_low", req_ready, 0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_hs_valid", rsp_valid, 1);
      @(negedge clk);
      chk("t4_ready_after", req_ready, 1);
      chk("t4_valid_after", rsp_valid, 0);
      chk("t4_result_kept", rsp_result, 16'h3333);

      run_op(16'h0100, 16'h0200, 1'b0, r, co, ov, z, lat);
      chk("t4b_result", r, 16'h0300);
      chk("t4b_latency", lat, 5);

      // Reset during the second RUN cycle discards the operation.
      @(posedge clk); #1;
      req_valid = 1'b1; req_a = 16'h5678; req_b = 16'h1111; req_cin = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 40);
      chk("t5_accept_timeout", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_req_ready", req_ready, 1);
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_result", rsp_result, 16'h0000);
      chk("t5_busy", busy, 0);
      repeat (6) @(negedge clk);

      run_op(16'h0003, 16'h0004, 1'b0, r, co, ov, z, lat);
      chk("t5b_result", r, 16'h0007);
      chk("t5b_cout", co, 0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Multi-cycle controller that runs WIDTH-bit operations on the team's 4-bit `ALU` by sequencing one nibble per clock, LSB first. The carry chains between nibbles through a register. It accepts operations on a valid/ready request channel and returns the assembled result, carry and overflow on a valid/ready response channel. It sits between a requester (datapath or test sequencer) and the single `ALU` instance, which it owns.

## Interface
- `WIDTH`, default 16: operand/result width. Must be a multiple of 4 and at least 4. `NIB = WIDTH/4`.
- `clk  in  1`: single clock; all logic is on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `req_valid  in  1`: request offered.
- `req_ready  out  1`: sequencer can accept a request.
- `req_a  in  WIDTH`: operand A.
- `req_b  in  WIDTH`: operand B.
- `req_s  in  4`: ALU function select, passed unchanged to every nibble.
- `req_cin  in  1`: carry into nibble 0.
- `rsp_valid  out  1`: result available.
- `rsp_ready  in  1`: consumer accepts the result.
- `rsp_result  out  WIDTH`: assembled result.
- `rsp_cout  out  1`: Cout of the most significant nibble.
- `rsp_overflow  out  1`: overflow of the most significant nibble, i.e. signed overflow of the full word.
- `busy  out  1`: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` at a clock edge, capture A, B, S and Cin into registers; clear the result register; set nibble index=0, carry=`req_cin`; go to RUN.
- RUN, one nibble per cycle:
  - ALU inputs are nibble[idx] of captured A and B, captured S, and carry as Cin.
  - At the edge, write ALU `result` into result[4*idx+:4], set carry ← `Cout` and ovf ← `overflow`.
  - If idx==NIB-1, go to DONE; otherwise idx++.
- Carry chains through every nibble regardless of S. For logic functions the ALU's Cout handling applies unchanged.
- DONE:
  - `rsp_valid`=1. `rsp_cout`=carry and `rsp_overflow`=ovf.
  - Hold all `rsp_*` stable until `rsp_ready`, then go to IDLE.
- `req_ready`=0 in RUN and DONE. A `req_valid` there is ignored and not queued.
- After leaving DONE, `rsp_result`, `rsp_cout` and `rsp_overflow` keep their last values; `rsp_valid`=0.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `busy`=0, `rsp_result`=0, `rsp_cout`=0, `rsp_overflow`=0, index and carry 0.
- Reset mid-operation, in RUN or DONE: the operation is discarded with no response, and the sequencer is in IDLE the cycle after the reset edge.
- WIDTH=4 (NIB=1): RUN lasts one cycle.

## Timing
- Accept handshake at edge E0, then RUN for NIB cycles. `rsp_valid` rises after edge E0+NIB, giving latency NIB+1 cycles to `rsp_valid` (5 for WIDTH=16).
- Response handshake at edge Ed: IDLE in the following cycle. `req_ready` cannot be high in the same cycle as `rsp_valid`.
- Maximum throughput is one operation per NIB+2 cycles.
- The ALU is purely combinational. Its path (capture registers → ALU → result/carry registers) must close in one cycle.

## Configuration
- `ALU_SEQ_ZERO_FLAG_EN` defined:
  - Adds output `rsp_zero  out  1`, which is 1 in DONE iff the assembled `rsp_result`==0.
  - It is tracked as a running AND of per-nibble zero tests, not a WIDTH-wide reduction.
  - Reset value 0; it holds its value like the other `rsp_*` outputs.
- Macro undefined: no port, no logic.

## Structure
- Package `alu_seq_pkg` holds:
  - `seq_state_t` enum (IDLE, RUN, DONE);
  - `nibble_t` (logic [3:0]);
  - constant `ALU_OP_ADD` = 4'b1001 (F = A plus B plus Cin).
- One sub-module: the existing `ALU`, instantiated once inside the sequencer. No other hierarchy.

## Test plan
All scenarios use WIDTH=16 and S=`ALU_OP_ADD`.
1. A=16'h1234, B=16'h0FFF, cin=0 → result 16'h2233, cout=0, overflow=0; `rsp_valid` rises exactly 5 cycles after the accept edge.
2. A=16'hFFFF, B=16'h0001, cin=0 → result 16'h0000, cout=1, overflow=0; `rsp_zero`=1 when the macro is defined.
3. A=16'h7FFF, B=16'h0001, cin=0 → result 16'h8000, cout=0, overflow=1. Then A=B=0, cin=1 → result 16'h0001 (carry-in reaches nibble 0 only).
4. Back-pressure: hold `rsp_ready`=0 for 10 cycles in DONE → `rsp_*` stable, `req_ready`=0, concurrent `req_valid` ignored. Raise `rsp_ready` → `req_ready`=1 the next cycle, and the next request completes normally.
5. Assert `rst` in the 2nd RUN cycle → next cycle IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, no response emitted. A following op 16'h0003+16'h0004 returns 16'h0007.
